// File: rtl/sti_packer.sv
// sti_packer: binarizes a 128x128 8-bit grayscale image against a latched
// threshold and packs 16 pixels per word (MSB = leftmost) into 1024 words.
// Optional build macro BORDER_CLR_EN forces row/col 0 and 127 pixels to 0.
module sti_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  threshold,
    output logic        gray_rd,
    output logic [13:0] gray_addr,
    input  logic [7:0]  gray_di,
    output logic        sti_wr,
    output logic [9:0]  sti_addr,
    output logic [15:0] sti_do,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        start_ok;
    logic [13:0] rd_addr;
    logic        rd_valid;
    logic [7:0]  thr_q;
    logic [15:0] shreg;
    logic [3:0]  bit_cnt;
    logic [9:0]  word_cnt;
    logic        wr_q;
    logic [9:0]  wr_addr_q;
    logic [15:0] wr_data_q;
    logic        pix_bit;
    logic [6:0]  pix_row;
    logic [6:0]  pix_col;

    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign pix_row   = word_cnt[9:3];
    assign pix_col   = {word_cnt[2:0], bit_cnt};

    assign gray_addr = rd_addr;
    assign sti_wr    = wr_q;
    assign sti_addr  = wr_addr_q;
    assign sti_do    = wr_data_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; restart requests during READ/DRAIN are ignored
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)                                state_nxt = READ;
            READ:    if (rd_addr == 14'd16383)                 state_nxt = DRAIN;
            DRAIN:   if (wr_q && (wr_addr_q == 10'd1023))      state_nxt = DONE;
            DONE:    if (start)                                state_nxt = READ;
            default:                                           state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        gray_rd = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            READ:    begin gray_rd = 1'b1; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Read address generation and threshold capture on accepted start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_addr  <= '0;
            thr_q    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (state == READ);
            if (start_ok) begin
                rd_addr <= '0;
                thr_q   <= threshold;
            end else if ((state == READ) && (rd_addr != 14'd16383)) begin
                rd_addr <= rd_addr + 14'd1;
            end
        end
    end

    // Binarize the returned pixel, clearing the image border when enabled
    always_comb begin
        pix_bit = (gray_di >= thr_q);
`ifdef BORDER_CLR_EN
        if ((pix_row == 7'd0) || (pix_row == 7'd127) ||
            (pix_col == 7'd0) || (pix_col == 7'd127))
            pix_bit = 1'b0;
`endif
    end

    // Shift returned pixels in MSB first and emit a word every 16 pixels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_q <= 1'b0;
            if (start_ok) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else if (rd_valid) begin
                shreg   <= {shreg[14:0], pix_bit};
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt == 4'd15) begin
                    wr_q      <= 1'b1;
                    wr_addr_q <= word_cnt;
                    wr_data_q <= {shreg[14:0], pix_bit};
                    word_cnt  <= word_cnt + 10'd1;
                end
            end
        end
    end

    // pix_row/pix_col are only consumed in the border-clear build
    logic unused_ok;
    assign unused_ok = ^{pix_row, pix_col};

endmodule

// File: tb/tb_sti_packer.sv
// Directed bench for sti_packer: full-image runs with a RAM model, checking
// read timing, write timing/addresses, packed words, busy/done and reset abort.
module tb_sti_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic        gray_rd;
    logic [13:0] gray_addr;
    logic [7:0]  gray_di = 8'd0;
    logic        sti_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;
    logic        busy;
    logic        done;

    int          vectors = 0;
    int          miscompares = 0;
    int          cur_mode = 0;
    logic [15:0] got_w [1024];

    sti_packer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .threshold (threshold),
        .gray_rd   (gray_rd),
        .gray_addr (gray_addr),
        .gray_di   (gray_di),
        .sti_wr    (sti_wr),
        .sti_addr  (sti_addr),
        .sti_do    (sti_do),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gray_val(input int mode, input int addr);
        int col;
        col = addr % 128;
        case (mode)
            0:       return 8'd255;
            1:       return 8'(col * 2);
            default: return 8'd100;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input int mode, input int k, input logic [7:0] thr);
        logic [15:0] w;
        int row;
        int col;
        row = k / 8;
        for (int j = 0; j < 16; j++) begin
            col = (k % 8) * 16 + j;
            w[15-j] = (gray_val(mode, row * 128 + col) >= thr);
`ifdef BORDER_CLR_EN
            if (row == 0 || row == 127 || col == 0 || col == 127) w[15-j] = 1'b0;
`endif
        end
        return w;
    endfunction

    // Grayscale RAM model: one-cycle read latency
    always @(posedge clk)
        if (gray_rd) gray_di <= gray_val(cur_mode, int'(gray_addr));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val(tag, {gray_rd, sti_wr, busy, done, 2'b00, gray_addr},
                  32'd0);
        check_val({tag, "_sti"}, {6'd0, sti_addr, sti_do}, 32'd0);
    endtask

    // One conversion run, sampled #1 after each edge; cycle 0 is the start cycle
    task automatic do_run(input int mode, input logic [7:0] thr, input int abort_at,
                          input bit restart_pulse, input bit from_done, input string tag);
        int rd_err = 0, wr_err = 0, word_err = 0, busy_err = 0, idle_err = 0;
        int nwr = 0, exp_nwr;
        logic [15:0] last_do = '0;
        logic exp_rd;
        cur_mode = mode;
        for (int i = 0; i < 1024; i++) got_w[i] = 16'hDEAD;
        @(negedge clk);
        check_val({tag, "_pre_done"}, {31'd0, done}, {31'd0, from_done});
        start = 1'b1;
        threshold = thr;
        for (int c = 1; c <= 16388; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                start = 1'b0;
                threshold = 8'd0;
                check_val({tag, "_c1_done"}, {31'd0, done}, 32'd0);
                check_val({tag, "_c1_addr"}, {18'd0, gray_addr}, 32'd0);
            end
            if (restart_pulse && c == 5000) start = 1'b1;
            if (restart_pulse && c == 5001) start = 1'b0;
            exp_rd = (c <= 16384);
            if (gray_rd !== exp_rd) rd_err++;
            if (exp_rd && gray_addr !== 14'(c - 1)) rd_err++;
            if (!exp_rd && gray_addr !== 14'd16383) rd_err++;
            if (busy !== (c <= 16386)) busy_err++;
            if (done !== (c >= 16387)) busy_err++;
            if (sti_wr === 1'b1) begin
                if (c != 16 * nwr + 18) wr_err++;
                if (sti_addr !== 10'(nwr)) wr_err++;
                if (sti_do !== exp_word(mode, nwr, thr)) word_err++;
                if (nwr < 1024) got_w[nwr] = sti_do;
                last_do = sti_do;
                nwr++;
            end else if (sti_wr !== 1'b0) begin
                wr_err++;
            end else if (nwr > 0) begin
                if (sti_addr !== 10'(nwr - 1) || sti_do !== last_do) wr_err++;
            end
            if (abort_at != 0 && c == abort_at) begin
                reset = 1'b0;
                #1;
                check_all_zero({tag, "_abort_zero"});
                repeat (3) begin
                    @(posedge clk);
                    #1;
                    if (sti_wr !== 1'b0 || busy !== 1'b0 || gray_rd !== 1'b0) idle_err++;
                end
                @(negedge clk);
                reset = 1'b1;
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    if (sti_wr !== 1'b0 || busy !== 1'b0 || gray_rd !== 1'b0 || done !== 1'b0)
                        idle_err++;
                end
                check_val({tag, "_post_abort_idle"}, idle_err, 0);
                break;
            end
        end
        exp_nwr = (abort_at != 0) ? ((abort_at - 18) / 16 + 1) : 1024;
        check_val({tag, "_nwr"}, nwr, exp_nwr);
        check_val({tag, "_rd_err"}, rd_err, 0);
        check_val({tag, "_wr_err"}, wr_err, 0);
        check_val({tag, "_word_err"}, word_err, 0);
        check_val({tag, "_busy_done_err"}, busy_err, 0);
    endtask

    initial begin
        #2;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("idle_busy", {31'd0, busy}, 32'd0);

        // all 255, threshold 128
        do_run(0, 8'd128, 0, 1'b0, 1'b0, "all255");
`ifdef BORDER_CLR_EN
        check_val("all255_w0",    got_w[0],    16'h0000);
        check_val("all255_w7",    got_w[7],    16'h0000);
        check_val("all255_w8",    got_w[8],    16'h7FFF);
        check_val("all255_w9",    got_w[9],    16'hFFFF);
        check_val("all255_w15",   got_w[15],   16'hFFFE);
        check_val("all255_w1016", got_w[1016], 16'h0000);
        check_val("all255_w1023", got_w[1023], 16'h0000);
`else
        check_val("all255_w0",    got_w[0],    16'hFFFF);
        check_val("all255_w8",    got_w[8],    16'hFFFF);
        check_val("all255_w15",   got_w[15],   16'hFFFF);
        check_val("all255_w1023", got_w[1023], 16'hFFFF);
`endif

        // gray = col*2, started from DONE, ignored restart at cycle 5000 with threshold 0
        do_run(1, 8'd128, 0, 1'b1, 1'b1, "ramp");
        check_val("ramp_w40", got_w[40], 16'h0000);
        check_val("ramp_w43", got_w[43], 16'h0000);
        check_val("ramp_w44", got_w[44], 16'hFFFF);
        check_val("ramp_w46", got_w[46], 16'hFFFF);
        check_val("ramp_w1000", got_w[1000], 16'h0000);
`ifdef BORDER_CLR_EN
        check_val("ramp_w47", got_w[47], 16'hFFFE);
`else
        check_val("ramp_w47", got_w[47], 16'hFFFF);
        check_val("ramp_w4",  got_w[4],  16'hFFFF);
`endif

        // gray 100, threshold 100, aborted by reset at cycle 3000
        do_run(2, 8'd100, 3000, 1'b0, 1'b1, "abort");
        check_val("abort_w100", got_w[100], 16'hFFFF);

        // gray 100, threshold 101, fresh run from IDLE after the abort
        do_run(2, 8'd101, 0, 1'b0, 1'b0, "thr101");
        check_val("thr101_w0",   got_w[0],   16'h0000);
        check_val("thr101_w500", got_w[500], 16'h0000);

        // gray 100, threshold 100, full run from DONE
        do_run(2, 8'd100, 0, 1'b0, 1'b1, "thr100");
        check_val("thr100_w100", got_w[100], 16'hFFFF);
        check_val("thr100_w513", got_w[513], 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
